// File: rtl/tone_pkg.sv
// tone_pkg: period table and types shared by the tone generator and the
// tone period decoder.
//   NUM_NOTES / NUM_OCT : table dimensions (12 notes x 9 octaves)
//   note_t / oct_t      : note index 0..11 (C..B), octave 0..8
//   base_period()       : octave-0 period in 1 MHz clock cycles; octave n
//                         is base_period(note) >> n
package tone_pkg;

    localparam int NUM_NOTES = 12;
    localparam int NUM_OCT   = 9;

    typedef logic [3:0] note_t;
    typedef logic [3:0] oct_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } cls_state_t;

    function automatic logic [15:0] base_period(input note_t n);
        case (n)
            4'd0:    return 16'd61156;
            4'd1:    return 16'd57723;
            4'd2:    return 16'd54484;
            4'd3:    return 16'd51427;
            4'd4:    return 16'd48539;
            4'd5:    return 16'd45815;
            4'd6:    return 16'd43243;
            4'd7:    return 16'd40816;
            4'd8:    return 16'd38525;
            4'd9:    return 16'd36364;
            4'd10:   return 16'd34323;
            4'd11:   return 16'd32396;
            default: return 16'd0;
        endcase
    endfunction

endpackage

// File: rtl/tone_sync_edge.sv
// tone_sync_edge: two-flop synchronizer for an asynchronous 1-bit input
// followed by a rising-edge detector.
//   clk  : system clock
//   rst  : synchronous active-high reset
//   din  : asynchronous input
//   rise : one-cycle pulse, high the cycle after the synchronized input
//          goes 0 -> 1 (consumed on the third clock edge after the pin moves)
module tone_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic prev_q, prev_d;

    always_comb begin
        meta_d = din;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign rise = sync_q & ~prev_q;

endmodule

// File: rtl/tone_period_decoder.sv
// tone_period_decoder: measures the period of a square-wave tone and
// classifies it against the 12-note x 9-octave period table in tone_pkg.
//   clk      : system clock (1 MHz; table constants assume this)
//   rst      : synchronous active-high reset
//   audio_in : asynchronous square-wave input
//   note     : note index 0..11 of the last reported match
//   octave   : octave 0..8 of the last reported match
//   valid    : one-cycle pulse when note/octave are updated
//   nomatch  : one-cycle pulse when a measurement matches no table entry
//   silent   : no rising edge within TIMEOUT cycles, or no period yet
// Optional build macro TONE_DECODER_CONFIRM_EN: a match is only reported
// once two consecutive completed scans land on the same table entry.
//
// Classifier states:
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | waiting for a measured period (pending first, then new)
//   ST_SCAN | testing one table entry per cycle, idx = oct*12 + note
module tone_period_decoder #(
    parameter int CNT_W   = 17,
    parameter int TIMEOUT = 65535,
    parameter int TOL_SH  = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       audio_in,
    output logic [3:0] note,
    output logic [3:0] octave,
    output logic       valid,
    output logic       nomatch,
    output logic       silent
);
    import tone_pkg::*;

    localparam logic [CNT_W-1:0] TO_CNT    = CNT_W'(TIMEOUT);
    localparam note_t            LAST_NOTE = 4'(NUM_NOTES - 1);
    localparam oct_t             LAST_OCT  = 4'(NUM_OCT - 1);

    logic rise;

    tone_sync_edge u_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (audio_in),
        .rise (rise)
    );

    // ------------------------------------------------------------------
    // Period counter
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             armed_q, armed_d;
    logic             timed_out;
    logic             per_stb;
    logic [CNT_W-1:0] per_val;

    always_comb begin
        timed_out = (cnt_q == TO_CNT);
        per_val   = cnt_q + 1'b1;
        per_stb   = 1'b0;
        cnt_d     = cnt_q;
        armed_d   = armed_q;
        if (rise) begin
            // The first edge after reset or silence only arms measurement.
            per_stb = armed_q && !timed_out;
            cnt_d   = '0;
            armed_d = 1'b1;
        end else if (timed_out) begin
            armed_d = 1'b0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Classifier
    // ------------------------------------------------------------------
    cls_state_t       state_q, state_d;
    note_t            note_idx_q, note_idx_d;
    oct_t             oct_idx_q, oct_idx_d;
    logic [CNT_W-1:0] scan_per_q, scan_per_d;
    logic             pend_vld_q, pend_vld_d;
    logic [CNT_W-1:0] pend_per_q, pend_per_d;
    note_t            note_q, note_d;
    oct_t             oct_q, oct_d;
    logic             valid_q, valid_d;
    logic             nomatch_q, nomatch_d;
    logic             silent_q, silent_d;
`ifdef TONE_DECODER_CONFIRM_EN
    logic             conf_vld_q, conf_vld_d;
    note_t            conf_note_q, conf_note_d;
    oct_t             conf_oct_q, conf_oct_d;
`endif

    logic [CNT_W-1:0] tbl_p, tol, diff;
    logic             hit, last_entry, upd;

    always_comb begin
        tbl_p      = CNT_W'(base_period(note_idx_q)) >> oct_idx_q;
        tol        = tbl_p >> TOL_SH;
        diff       = (scan_per_q >= tbl_p) ? (scan_per_q - tbl_p) : (tbl_p - scan_per_q);
        hit        = (diff <= tol);
        last_entry = (note_idx_q == LAST_NOTE) && (oct_idx_q == LAST_OCT);
    end

    always_comb begin
        state_d    = state_q;
        note_idx_d = note_idx_q;
        oct_idx_d  = oct_idx_q;
        scan_per_d = scan_per_q;
        pend_vld_d = pend_vld_q;
        pend_per_d = pend_per_q;
        note_d     = note_q;
        oct_d      = oct_q;
        valid_d    = 1'b0;
        nomatch_d  = 1'b0;
        upd        = 1'b0;
`ifdef TONE_DECODER_CONFIRM_EN
        conf_vld_d  = conf_vld_q;
        conf_note_d = conf_note_q;
        conf_oct_d  = conf_oct_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (pend_vld_q) begin
                    // A period arriving this same cycle refills the slot.
                    scan_per_d = pend_per_q;
                    pend_vld_d = per_stb;
                    if (per_stb) begin
                        pend_per_d = per_val;
                    end
                    note_idx_d = '0;
                    oct_idx_d  = '0;
                    state_d    = ST_SCAN;
                end else if (per_stb) begin
                    scan_per_d = per_val;
                    note_idx_d = '0;
                    oct_idx_d  = '0;
                    state_d    = ST_SCAN;
                end
            end

            ST_SCAN: begin
                if (per_stb) begin
                    pend_vld_d = 1'b1;
                    pend_per_d = per_val;
                end
                if (hit) begin
`ifdef TONE_DECODER_CONFIRM_EN
                    upd = conf_vld_q && (conf_note_q == note_idx_q) && (conf_oct_q == oct_idx_q);
                    conf_vld_d  = 1'b1;
                    conf_note_d = note_idx_q;
                    conf_oct_d  = oct_idx_q;
`else
                    upd = 1'b1;
`endif
                    state_d = ST_IDLE;
                end else if (last_entry) begin
                    nomatch_d = 1'b1;
`ifdef TONE_DECODER_CONFIRM_EN
                    conf_vld_d = 1'b0;
`endif
                    state_d = ST_IDLE;
                end else if (note_idx_q == LAST_NOTE) begin
                    note_idx_d = '0;
                    oct_idx_d  = oct_idx_q + 4'd1;
                end else begin
                    note_idx_d = note_idx_q + 4'd1;
                end
            end

            default: state_d = ST_IDLE;
        endcase

        if (upd) begin
            note_d  = note_idx_q;
            oct_d   = oct_idx_q;
            valid_d = 1'b1;
        end

        silent_d = silent_q;
        if (valid_d) begin
            silent_d = 1'b0;
        end
        if (timed_out) begin
            silent_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            armed_q    <= 1'b0;
            state_q    <= ST_IDLE;
            note_idx_q <= '0;
            oct_idx_q  <= '0;
            scan_per_q <= '0;
            pend_vld_q <= 1'b0;
            pend_per_q <= '0;
            note_q     <= '0;
            oct_q      <= '0;
            valid_q    <= 1'b0;
            nomatch_q  <= 1'b0;
            silent_q   <= 1'b1;
`ifdef TONE_DECODER_CONFIRM_EN
            conf_vld_q  <= 1'b0;
            conf_note_q <= '0;
            conf_oct_q  <= '0;
`endif
        end else begin
            cnt_q      <= cnt_d;
            armed_q    <= armed_d;
            state_q    <= state_d;
            note_idx_q <= note_idx_d;
            oct_idx_q  <= oct_idx_d;
            scan_per_q <= scan_per_d;
            pend_vld_q <= pend_vld_d;
            pend_per_q <= pend_per_d;
            note_q     <= note_d;
            oct_q      <= oct_d;
            valid_q    <= valid_d;
            nomatch_q  <= nomatch_d;
            silent_q   <= silent_d;
`ifdef TONE_DECODER_CONFIRM_EN
            conf_vld_q  <= conf_vld_d;
            conf_note_q <= conf_note_d;
            conf_oct_q  <= conf_oct_d;
`endif
        end
    end

    assign note    = note_q;
    assign octave  = oct_q;
    assign valid   = valid_q;
    assign nomatch = nomatch_q;
    assign silent  = silent_q;

endmodule

// File: tb/tb_tone_period_decoder.sv
// Bench for tone_period_decoder. Square-wave periods come from a vector
// table; each latched period pushes its expected outcome onto a scoreboard
// queue that a monitor pops whenever valid or nomatch pulses.
// Honours TONE_DECODER_CONFIRM_EN in its expectation model.
`timescale 1ns/1ps
module tb_tone_period_decoder;

    localparam int LAT_MAX = 112;
    localparam int NV      = 14;

    logic       clk = 1'b0;
    logic       rst;
    logic       audio_in;
    logic [3:0] note, octave;
    logic       valid, nomatch, silent;

    int         cyc   = 0;
    int         n_vec = 0;
    int         n_err = 0;
    logic [3:0] exp_note = 4'd0;
    logic [3:0] exp_oct  = 4'd0;
`ifdef TONE_DECODER_CONFIRM_EN
    bit         conf_vld  = 1'b0;
    logic [3:0] conf_note = 4'd0;
    logic [3:0] conf_oct  = 4'd0;
`endif

    typedef struct {
        bit         is_match;
        logic [3:0] note;
        logic [3:0] oct;
        logic [3:0] hold_note;
        logic [3:0] hold_oct;
        int         t_push;
        bit         chk_lat;
    } exp_t;

    typedef struct {
        int         period;
        bit         is_match;
        logic [3:0] note;
        logic [3:0] oct;
        bit         chk_lat;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[NV];

    tone_period_decoder dut (
        .clk      (clk),
        .rst      (rst),
        .audio_in (audio_in),
        .note     (note),
        .octave   (octave),
        .valid    (valid),
        .nomatch  (nomatch),
        .silent   (silent)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Expected outcome of one latched period; with confirmation enabled a
    // match is only reported when it repeats the previous scan's entry.
    task automatic push_result(input bit is_match, input logic [3:0] n,
                               input logic [3:0] o, input bit chk_lat);
        exp_t e;
        bit   emit;
        emit = 1'b1;
`ifdef TONE_DECODER_CONFIRM_EN
        if (is_match) begin
            emit      = conf_vld && (conf_note == n) && (conf_oct == o);
            conf_vld  = 1'b1;
            conf_note = n;
            conf_oct  = o;
        end else begin
            conf_vld = 1'b0;
        end
`endif
        if (is_match && emit) begin
            exp_note = n;
            exp_oct  = o;
        end
        if (emit) begin
            e.is_match  = is_match;
            e.note      = n;
            e.oct       = o;
            e.hold_note = exp_note;
            e.hold_oct  = exp_oct;
            e.t_push    = cyc;
            e.chk_lat   = chk_lat;
            sb_q.push_back(e);
        end
    endtask

    // Waits n cycles after a rising edge (input high), dropping the input
    // halfway, so that the caller's next rise lands exactly n cycles later.
    task automatic gap(input int n);
        repeat (n / 2) @(negedge clk);
        audio_in = 1'b0;
        repeat (n - n / 2) @(negedge clk);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_note"}, note, 0);
        check({tag, "_octave"}, octave, 0);
        check({tag, "_valid"}, valid, 0);
        check({tag, "_nomatch"}, nomatch, 0);
        check({tag, "_silent"}, silent, 1);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && (valid || nomatch)) begin
            if (sb_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_pulse: valid=%0b nomatch=%0b, expected no pulse (cycle %0d)",
                         valid, nomatch, cyc);
            end else begin
                e = sb_q.pop_front();
                check("pulse_kind", int'({valid, nomatch}), e.is_match ? 2 : 1);
                if (e.is_match) begin
                    check("match_note", note, e.note);
                    check("match_octave", octave, e.oct);
                    check("silent_on_valid", silent, 0);
                end else begin
                    check("held_note", note, e.hold_note);
                    check("held_octave", octave, e.hold_oct);
                end
                if (e.chk_lat) begin
                    n_vec++;
                    if (cyc - e.t_push > LAT_MAX) begin
                        n_err++;
                        $display("FAIL latency: got %0d cycles, required at most %0d", cyc - e.t_push, LAT_MAX);
                    end
                end
            end
        end
    end

    initial begin
        vecs[0]  = '{2272,  1'b1, 4'd9,  4'd4, 1'b1};   // A4
        vecs[1]  = '{2272,  1'b1, 4'd9,  4'd4, 1'b1};
        vecs[2]  = '{61156, 1'b1, 4'd0,  4'd0, 1'b1};   // C0, largest entry
        vecs[3]  = '{126,   1'b1, 4'd11, 4'd8, 1'b1};   // B8, smallest entry
        vecs[4]  = '{126,   1'b1, 4'd11, 4'd8, 1'b1};
        vecs[5]  = '{30,    1'b0, 4'd0,  4'd0, 1'b0};   // lands while scanning
        vecs[6]  = '{126,   1'b1, 4'd11, 4'd8, 1'b0};   // queued behind it
        vecs[7]  = '{2950,  1'b0, 4'd0,  4'd0, 1'b1};   // between E4 and F4
        vecs[8]  = '{2272,  1'b1, 4'd9,  4'd4, 1'b1};
        vecs[9]  = '{2145,  1'b1, 4'd10, 4'd4, 1'b1};   // A#4
        vecs[10] = '{2272,  1'b1, 4'd9,  4'd4, 1'b1};
        vecs[11] = '{2145,  1'b1, 4'd10, 4'd4, 1'b1};
        vecs[12] = '{2272,  1'b1, 4'd9,  4'd4, 1'b1};
        vecs[13] = '{2272,  1'b1, 4'd9,  4'd4, 1'b1};

        rst      = 1'b1;
        audio_in = 1'b0;
        repeat (4) @(negedge clk);
        check_reset_vals("reset");
        rst = 1'b0;
        @(negedge clk);
        audio_in = 1'b1;                 // arming edge, no period

        for (int i = 0; i < NV; i++) begin
            if (i == 0) check("silent_before_first_period", silent, 1);
            gap(vecs[i].period);
            audio_in = 1'b1;
            push_result(vecs[i].is_match, vecs[i].note, vecs[i].oct, vecs[i].chk_lat);
        end

        // Silence: no rising edge after the last table edge.
        repeat (200) @(negedge clk);
        audio_in = 1'b0;
        check("drained_after_table", sb_q.size(), 0);
        repeat (65330) @(negedge clk);
        check("silent_before_timeout", silent, 0);
        repeat (15) @(negedge clk);
        check("silent_after_timeout", silent, 1);
        check("silence_holds_note", note, exp_note);
        check("silence_holds_octave", octave, exp_oct);

        // First edge after silence only arms; the next two classify.
        audio_in = 1'b1;
        gap(2272);
        audio_in = 1'b1;
        push_result(1'b1, 4'd9, 4'd4, 1'b1);
        gap(2272);
        audio_in = 1'b1;
        push_result(1'b1, 4'd9, 4'd4, 1'b1);
        repeat (150) @(negedge clk);
        check("silent_cleared", silent, 0);
        check("drained_after_silence", sb_q.size(), 0);

        // Reset while an A4 scan is in flight; its result must never appear.
        gap(2272);
        audio_in = 1'b1;
        repeat (30) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_vals("mid_scan_reset");
        rst      = 1'b0;
        exp_note = 4'd0;
        exp_oct  = 4'd0;
`ifdef TONE_DECODER_CONFIRM_EN
        conf_vld = 1'b0;
`endif
        repeat (300) @(negedge clk);
        check("silent_after_abort", silent, 1);
        check("drained_at_end", sb_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
